// File: rtl/parity_rx_pkg.sv
// Shared definitions for the parity_rx serial receiver: FSM encoding and parity-sense constants.
package parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 0;

  // Final accumulated parity (data XOR parity bit) that marks a clean frame.
  function automatic logic par_expected(input int even);
    return (even == PAR_EVEN) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/par_acc.sv
// One-bit XOR accumulator: clr zeroes the running value, en folds d into it.
module par_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver (start, DATA_BITS LSB-first, parity, stop) with a one-deep
// output register, parity/framing error flags and a sticky overrun indicator.
module parity_rx
  import parity_rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int EVEN      = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  input  logic                 IN_BIT,
  input  logic                 OUT_READY,
  output logic [DATA_BITS-1:0] OUT_DATA,
  output logic                 OUT_VALID,
  output logic                 OUT_PERR,
  output logic                 OUT_FERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int   CNT_W   = $clog2(DATA_BITS + 1);
  localparam logic PAR_EXP = par_expected(EVEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  rx_state_t state, state_next;

  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_q;

  logic cnt_clr;
  logic shift_en;
  logic par_clr;
  logic par_en;
  logic complete;

  logic frame_perr;
  logic frame_ferr;
  logic drain;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; every transition is qualified by IN_VALID
  always_comb begin
    state_next = state;
    if (IN_VALID) begin
      unique case (state)
        IDLE:    if (!IN_BIT) state_next = DATA;
        DATA:    if (bit_cnt == LAST_BIT) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Control outputs decoded from the current state
  always_comb begin
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    par_clr  = 1'b0;
    par_en   = 1'b0;
    complete = 1'b0;
    BUSY     = (state != IDLE);
    if (IN_VALID) begin
      unique case (state)
        IDLE: begin
          cnt_clr = !IN_BIT;
          par_clr = !IN_BIT;
        end
        DATA: begin
          shift_en = 1'b1;
          par_en   = 1'b1;
        end
        PARITY:  par_en   = 1'b1;
        STOP:    complete = 1'b1;
        default: ;
      endcase
    end
  end

  // Bit counter saturates at DATA_BITS, so it can never wrap inside a frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt <= '0;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
    end else if (shift_en && bit_cnt != CNT_W'(DATA_BITS)) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // New bits enter at the MSB so the first line bit ends up in bit 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {IN_BIT, shift_reg[DATA_BITS-1:1]};
    end
  end

  par_acc u_par_acc (
    .clk (CLK),
    .rst (RST),
    .clr (par_clr),
    .en  (par_en),
    .d   (IN_BIT),
    .q   (par_q)
  );

  // par_q already includes the parity bit once the FSM reaches STOP
  assign frame_perr = par_q ^ PAR_EXP;
  assign frame_ferr = !IN_BIT;
  assign drain      = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_PERR  <= 1'b0;
      OUT_FERR  <= 1'b0;
      OVERRUN   <= 1'b0;
    end else if (complete) begin
      if (!OUT_VALID || OUT_READY) begin
        OUT_DATA  <= shift_reg;
        OUT_VALID <= 1'b1;
        OUT_PERR  <= frame_perr;
        OUT_FERR  <= frame_ferr;
      end else begin
        OVERRUN <= 1'b1;
      end
    end else if (drain) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_rx.sv
// Directed self-checking bench for parity_rx (even-parity and odd-parity instances).
module tb_parity_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_BIT = 1'b1;
  logic       OUT_READY = 1'b0;

  logic [7:0] e_data, o_data;
  logic       e_valid, e_perr, e_ferr, e_ovr, e_busy;
  logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  parity_rx #(.DATA_BITS(8), .EVEN(1)) dut_even (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_BIT(IN_BIT), .OUT_READY(OUT_READY),
    .OUT_DATA(e_data), .OUT_VALID(e_valid), .OUT_PERR(e_perr), .OUT_FERR(e_ferr),
    .OVERRUN(e_ovr), .BUSY(e_busy)
  );

  parity_rx #(.DATA_BITS(8), .EVEN(0)) dut_odd (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_BIT(IN_BIT), .OUT_READY(OUT_READY),
    .OUT_DATA(o_data), .OUT_VALID(o_valid), .OUT_PERR(o_perr), .OUT_FERR(o_ferr),
    .OVERRUN(o_ovr), .BUSY(o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      int unsigned n;
      n = $urandom_range(0, 3);
      for (int unsigned i = 0; i < n; i++) begin
        @(negedge CLK);
        IN_VALID = $urandom_range(0, 1);
        IN_BIT   = $urandom_range(0, 1);
        if (IN_VALID) begin
          IN_VALID = 1'b0;
        end
        @(posedge CLK);
      end
    end
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_BIT   = b;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_BIT   = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input bit gaps, input bit ready_on_stop);
    send_bit(1'b0, gaps);
    for (int unsigned i = 0; i < 8; i++) send_bit(d[i], gaps);
    send_bit(par, gaps);
    if (ready_on_stop) begin
      @(negedge CLK);
      IN_VALID  = 1'b1;
      IN_BIT    = stp;
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      IN_VALID  = 1'b0;
      IN_BIT    = 1'b1;
      OUT_READY = 1'b0;
    end else begin
      send_bit(stp, gaps);
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_data",  {24'd0, e_data}, 32'h00);
    check("rst_valid", {31'd0, e_valid}, 32'd0);
    check("rst_perr",  {31'd0, e_perr}, 32'd0);
    check("rst_ferr",  {31'd0, e_ferr}, 32'd0);
    check("rst_ovr",   {31'd0, e_ovr}, 32'd0);
    check("rst_busy",  {31'd0, e_busy}, 32'd0);
    repeat (2) @(posedge CLK);
    release_reset();

    // Idle line and frozen cycles keep the receiver in IDLE
    send_bit(1'b1, 1'b0);
    check("idle_busy", {31'd0, e_busy}, 32'd0);

    // Clean frame 0x05
    OUT_READY = 1'b1;
    send_bit(1'b0, 1'b0);
    check("start_busy", {31'd0, e_busy}, 32'd1);
    repeat (3) @(posedge CLK);
    check("freeze_busy", {31'd0, e_busy}, 32'd1);
    for (int unsigned i = 0; i < 8; i++) send_bit(i == 0 || i == 2, 1'b0);
    send_bit(1'b0, 1'b0);
    check("pre_stop_valid", {31'd0, e_valid}, 32'd0);
    send_bit(1'b1, 1'b0);
    check("f1_valid", {31'd0, e_valid}, 32'd1);
    check("f1_data",  {24'd0, e_data}, 32'h05);
    check("f1_perr",  {31'd0, e_perr}, 32'd0);
    check("f1_ferr",  {31'd0, e_ferr}, 32'd0);
    check("f1_busy",  {31'd0, e_busy}, 32'd0);
    @(posedge CLK); #1;
    check("f1_drain", {31'd0, e_valid}, 32'd0);

    // Parity error, then framing error
    send_frame(8'h05, 1'b1, 1'b1, 1'b0, 1'b0);
    check("perr_data", {24'd0, e_data}, 32'h05);
    check("perr_flag", {31'd0, e_perr}, 32'd1);
    check("perr_ferr", {31'd0, e_ferr}, 32'd0);
    send_frame(8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ferr_flag", {31'd0, e_ferr}, 32'd1);
    check("ferr_perr", {31'd0, e_perr}, 32'd0);
    @(posedge CLK); #1;

    // Overrun: second frame dropped while output is held
    OUT_READY = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_first_data", {24'd0, e_data}, 32'hA5);
    check("ovr_first_ovr",  {31'd0, e_ovr}, 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_hold_data",  {24'd0, e_data}, 32'hA5);
    check("ovr_hold_valid", {31'd0, e_valid}, 32'd1);
    check("ovr_set",        {31'd0, e_ovr}, 32'd1);
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    check("ovr_drain_valid", {31'd0, e_valid}, 32'd0);
    check("ovr_sticky",      {31'd0, e_ovr}, 32'd1);

    pulse_reset();
    check("ovr_rst_clear", {31'd0, e_ovr}, 32'd0);
    release_reset();

    // Completion coincident with drain replaces the word without overrun
    OUT_READY = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    check("swap_data",  {24'd0, e_data}, 32'h3C);
    check("swap_valid", {31'd0, e_valid}, 32'd1);
    check("swap_ovr",   {31'd0, e_ovr}, 32'd0);
    @(posedge CLK); #1;
    check("swap_hold",  {24'd0, e_data}, 32'h3C);
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    check("swap_drain", {31'd0, e_valid}, 32'd0);

    // Reset mid-frame abandons it; next frame decodes normally
    send_bit(1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    check("mid_busy", {31'd0, e_busy}, 32'd1);
    pulse_reset();
    check("mid_rst_busy", {31'd0, e_busy}, 32'd0);
    release_reset();
    for (int unsigned i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("mid_no_valid", {31'd0, e_valid}, 32'd0);
    check("mid_no_ovr",   {31'd0, e_ovr}, 32'd0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ff_data", {24'd0, e_data}, 32'hFF);
    check("ff_perr", {31'd0, e_perr}, 32'd0);
    @(posedge CLK); #1;

    // Gapped frame 0x5A with parity 1: clean for odd, error for even
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    check("odd_valid", {31'd0, o_valid}, 32'd1);
    check("odd_data",  {24'd0, o_data}, 32'h5A);
    check("odd_perr",  {31'd0, o_perr}, 32'd0);
    check("odd_ferr",  {31'd0, o_ferr}, 32'd0);
    check("even_data", {24'd0, e_data}, 32'h5A);
    check("even_perr", {31'd0, e_perr}, 32'd1);
    @(posedge CLK); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
